fp_result_normalizer: RTL and testbench

//  Back end of the FP add/sub datapath; consumes the mantissa adder's result (sum, c_out, signS, ready).

---
 rtl/fp_result_normalizer.sv | 89 ++++++++
 tb/tb_fp_result_normalizer.sv | 143 ++++++++++++++
 2 files changed

// File: rtl/fp_result_normalizer.sv
// fp_result_normalizer: normalises an add/sub adder result one shift per clock and packs an IEEE-754 single.
module fp_result_normalizer #(
  parameter int MANT_W = 24,
  parameter int EXP_W  = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              en,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [MANT_W-1:0] sum_in,
  input  logic              c_out_in,
  input  logic              sign_in,
  input  logic [EXP_W-1:0]  exp_in,
  output logic [31:0]       result,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              zero,
  output logic              overflow,
  output logic              underflow
);
  localparam logic [EXP_W-1:0] ONE  = {{(EXP_W-1){1'b0}}, 1'b1};
  localparam logic [EXP_W-1:0] EMAX = {{(EXP_W-1){1'b1}}, 1'b0};
  localparam logic [EXP_W-1:0] ALL1 = {EXP_W{1'b1}};
  typedef enum logic [1:0] {IDLE, NORM, PACK, HOLD} state_t;
  state_t state;
  logic [MANT_W-1:0] mant;
  logic [EXP_W-1:0] exp;
  logic sgn, cflag;
  logic is_zero, is_ovf, is_den;
  assign in_ready = (state == IDLE);
  assign is_zero  = (mant == '0);
  assign is_ovf   = !is_zero && (exp > EMAX);
  assign is_den   = !is_zero && !is_ovf && !mant[MANT_W-1] && (exp <= ONE);
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= IDLE;
      mant      <= '0;
      exp       <= '0;
      sgn       <= 1'b0;
      cflag     <= 1'b0;
      result    <= '0;
      out_valid <= 1'b0;
      zero      <= 1'b0;
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else if (en) begin
      case (state)
        IDLE: if (in_valid) begin
          mant  <= sum_in;
          exp   <= exp_in;
          sgn   <= sign_in;
          cflag <= c_out_in;
          state <= NORM;
        end
        NORM: if (cflag) begin
          mant  <= {1'b1, mant[MANT_W-1:1]};
          exp   <= (exp == ALL1) ? exp : exp + ONE;
          cflag <= 1'b0;
          state <= PACK;
        end else if (is_zero || mant[MANT_W-1] || exp <= ONE) begin
          state <= PACK;
        end else begin
          mant <= mant << 1;
          exp  <= exp - ONE;
        end
        PACK: begin
          result    <= is_zero ? '0 :
                       is_ovf  ? {sgn, ALL1, {(MANT_W-1){1'b0}}} :
                       is_den  ? {sgn, {EXP_W{1'b0}}, mant[MANT_W-2:0]} :
                                 {sgn, exp, mant[MANT_W-2:0]};
          zero      <= is_zero;
          overflow  <= is_ovf;
          underflow <= is_den;
          out_valid <= 1'b1;
          state     <= HOLD;
        end
        HOLD: if (out_ready) begin
          out_valid <= 1'b0;
          zero      <= 1'b0;
          overflow  <= 1'b0;
          underflow <= 1'b0;
          state     <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_fp_result_normalizer.sv
// tb_fp_result_normalizer: directed and random checks of the normaliser against an arithmetic reference model.
module tb_fp_result_normalizer;
  logic clk = 0, rst = 0, en = 1, in_valid = 0, out_ready = 0;
  logic [23:0] sum_in = '0;
  logic c_out_in = 0, sign_in = 0;
  logic [7:0] exp_in = '0;
  logic in_ready, out_valid, zero, overflow, underflow;
  logic [31:0] result;
  int checks = 0, errors = 0;

  fp_result_normalizer dut (
    .clk(clk), .rst(rst), .en(en), .in_valid(in_valid), .in_ready(in_ready),
    .sum_in(sum_in), .c_out_in(c_out_in), .sign_in(sign_in), .exp_in(exp_in),
    .result(result), .out_valid(out_valid), .out_ready(out_ready),
    .zero(zero), .overflow(overflow), .underflow(underflow)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
    checks++;
    assert (got === want) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, got, want);
    end
  endtask

  // Reference: leading-one search limited by how far the exponent may fall, then IEEE packing.
  function automatic void model(input logic [23:0] sm, input bit c, input int e, input bit s,
                                output logic [31:0] r, output bit z, output bit ov,
                                output bit un, output int k);
    logic [23:0] m;
    int ee, p, lim;
    k = 0; z = 0; ov = 0; un = 0; r = '0; m = sm; ee = e;
    if (c) begin
      m = {1'b1, sm[23:1]};
      ee = e + 1;
    end else if (sm == 0) begin
      z = 1;
      return;
    end else begin
      p = 23;
      while (!sm[p]) p--;
      lim = (e > 1) ? e - 1 : 0;
      k = (23 - p < lim) ? 23 - p : lim;
      m = sm << k;
      ee = e - k;
    end
    if (ee > 254) begin
      r = {s, 8'hFF, 23'h0};
      ov = 1;
    end else if (!m[23]) begin
      r = {s, 8'h00, m[22:0]};
      un = 1;
    end else begin
      r = {s, ee[7:0], m[22:0]};
    end
  endfunction

  task automatic run(input string tag, input logic [23:0] sm, input bit c, input int e,
                     input bit s, input int stall_at, input int stall_len, input int hold);
    logic [31:0] r;
    bit z, ov, un;
    int k, edges;
    model(sm, c, e, s, r, z, ov, un, k);
    @(negedge clk);
    chk({tag, "_in_ready"}, 32'(in_ready), 32'd1);
    sum_in = sm; c_out_in = c; exp_in = e[7:0]; sign_in = s; in_valid = 1;
    @(posedge clk);
    @(negedge clk);
    in_valid = 0;
    edges = 0;
    while (!out_valid && edges < 80) begin
      en = !(stall_len > 0 && edges >= stall_at && edges < stall_at + stall_len);
      @(posedge clk);
      edges++;
      @(negedge clk);
    end
    en = 1;
    chk({tag, "_latency"}, 32'(edges), 32'(k + 2 + stall_len));
    chk({tag, "_result"}, result, r);
    chk({tag, "_flags"}, {29'd0, zero, overflow, underflow}, {29'd0, z, ov, un});
    chk({tag, "_in_ready_busy"}, 32'(in_ready), 32'd0);
    if (hold > 0) begin
      repeat (hold) @(negedge clk);
      chk({tag, "_hold_result"}, result, r);
      chk({tag, "_hold_valid"}, 32'(out_valid), 32'd1);
      en = 0; out_ready = 1;
      @(negedge clk);
      chk({tag, "_en0_valid"}, 32'(out_valid), 32'd1);
      en = 1; out_ready = 0;
    end
    out_ready = 1;
    @(negedge clk);
    out_ready = 0;
    chk({tag, "_release"}, {28'd0, out_valid, zero, overflow, underflow}, 32'd0);
  endtask

  initial begin
    logic [23:0] rs;
    #12;
    chk("reset_result", result, 32'h0);
    chk("reset_outs", {27'd0, out_valid, zero, overflow, underflow, in_ready}, 32'd1);
    rst = 1;
    run("t1_normal", 24'hC00000, 0, 130, 0, 0, 0, 0);
    chk("t1_const", result, 32'h41400000);
    run("t2_carry", 24'h800000, 1, 127, 0, 0, 0, 0);
    chk("t2_const", result, 32'h40400000);
    run("t3_shift23", 24'h000001, 0, 150, 1, 0, 0, 0);
    chk("t3_const", result, 32'hBF800000);
    run("t4_zero", 24'h000000, 0, 77, 1, 0, 0, 0);
    chk("t4_const", result, 32'h00000000);
    run("t5_ovf", 24'h800000, 1, 254, 0, 0, 0, 5);
    chk("t5_const", result, 32'h7F800000);
    run("t5_ovf255", 24'hA00000, 0, 255, 1, 0, 0, 0);
    run("t6_denorm", 24'h000100, 0, 3, 0, 0, 0, 0);
    chk("t6_const", result, 32'h00000400);
    run("t6_stall", 24'h000100, 0, 3, 0, 1, 3, 0);
    run("t6_exp0", 24'h000123, 0, 0, 1, 0, 0, 0);
    // Abort mid-shift with an asynchronous reset
    @(negedge clk);
    sum_in = 24'h000001; c_out_in = 0; exp_in = 8'd150; sign_in = 1; in_valid = 1;
    @(posedge clk);
    @(negedge clk);
    in_valid = 0;
    repeat (9) @(negedge clk);
    rst = 0;
    #1;
    chk("abort_in_ready", 32'(in_ready), 32'd1);
    chk("abort_valid", 32'(out_valid), 32'd0);
    @(negedge clk);
    rst = 1;
    repeat (30) @(negedge clk);
    chk("abort_no_valid", {30'd0, out_valid, in_ready}, 32'd1);
    run("post_abort", 24'h400000, 0, 100, 0, 0, 0, 0);
    for (int i = 0; i < 40; i++) begin
      rs = 24'($urandom) >> $urandom_range(0, 23);
      run("rand", rs, $urandom_range(0, 4) == 0, $urandom_range(0, 255), 1'($urandom), 0, 0, 0);
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
